bcd_clock_core: RTL and testbench
=================================

# bcd_clock_core

Parametrised time-of-day counter for the digital clock: divides the system clock to a 1 Hz tick, keeps hours, minutes and seconds as six BCD digits, and lets the user set any field with increment/decrement buttons with press-and-hold auto-repeat. It sits between the button inputs and the 7-segment display mux, and replaces the fixed ripple counter used in the first clock build.

## Interface
- TICK_DIV, 50_000_000: clk cycles per 1 s tick; legal ≥ 2.
- SET_REPEAT, 25_000_000: cycles a button is held after its first step before auto-repeat starts; legal ≥ 2.
- REPEAT_PERIOD, 5_000_000: cycles between auto-repeat steps; legal ≥ 2.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  1 = timekeeping enabled; 0 = time frozen, prescaler held at 0.
- sel  in  2  field to set: 00 seconds, 01 minutes, 10 hours, 11 none.
- btn_inc  in  1  increment button, active-high, asynchronous level.
- btn_dec  in  1  decrement button, active-high, asynchronous level.
- sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  out  4 each  BCD display digits, registered.
- tick_1hz  out  1  one-cycle pulse on every timekeeping advance.
- day_wrap  out  1  one-cycle pulse when 23:59:59 advances to 00:00:00.
- pm  out  1  PM indicator (see Configuration).

## Operation
- Buttons pass through 2-flop synchronisers; the synchronised levels are inc_s and dec_s.
- Prescaler counts 0..TICK_DIV-1 while run=1 and no button is held; tick on the cycle it equals TICK_DIV-1, then it wraps to 0.
- Tick advances seconds, with carry into minutes at 59→00 and carry into hours at 59→00; hours wrap 23→00 with day_wrap. tick_1hz and day_wrap assert in the same cycle the digits update.
- Internal hours range 0..23. Every digit always holds a legal BCD value: lo 0..9; sec_hi/min_hi 0..5; hr_hi 0..2.
- Button FSM states: IDLE, FIRST, HOLD, REPEAT.
  - IDLE → FIRST on a rising edge of exactly one of inc_s/dec_s; one step is applied.
  - FIRST → HOLD next cycle; the hold counter counts SET_REPEAT cycles.
  - HOLD → REPEAT with one step at expiry; REPEAT applies one step every REPEAT_PERIOD cycles.
  - Any state → IDLE when the active button is released, or when both buttons are high.
  - Both buttons high: no step, and the FSM is held in IDLE.
- A set step changes only the selected field, wrapping with no carry: sec/min 59+1→00 and 00-1→59; hours 23+1→00 and 00-1→23. sel=11: no step, but the FSM still runs. A change of sel mid-hold applies the remaining steps to the new field.
- While inc_s or dec_s is high, the prescaler is held at 0 and no tick occurs. Timekeeping resumes a full TICK_DIV cycles after release, so a tick and a set step can never coincide.
- A stepped seconds field is not cleared.

## Timing
- Reset: all six digits 0, tick_1hz 0, day_wrap 0, pm 0, prescaler 0, FSM IDLE.
- Exception under TIME_CNT_12H_EN: the digit outputs read 1,2:0,0:0,0 (12:00:00 AM).
- Reset mid-hold or mid-count takes effect immediately. After release, a button that is still held does not step until it is released and pressed again.
- Button latency: btn sampled high at edge N → synchroniser output high at N+1 → step applied at N+2. The new digits are valid after edge N+2.
- Auto-repeat: the second step comes SET_REPEAT cycles after the first. Each later step comes REPEAT_PERIOD cycles after the previous one.
- Tick latency: the digits update at the same edge the prescaler wraps. From release or run rising to the first tick is TICK_DIV cycles.

## Configuration
- TIME_CNT_12H_EN defined:
  - Hour digits show 12-hour format: internal 0 → 12, 1..12 → same, 13..23 → 1..11.
  - hr_hi shows a leading 0 as value 0.
  - pm=1 for internal hours 12..23.
  - The conversion is registered, with the same timing as the other digits.
- TIME_CNT_12H_EN undefined: hour digits show 00..23 and pm is tied 0.

## Test plan
Bench parameters: TICK_DIV=4, SET_REPEAT=6, REPEAT_PERIOD=3.
- Reset then run=1 for 240 cycles → digits show 00:01:00, with 60 tick_1hz pulses and one every 4 cycles.
- Preload 23:59:59 via sets, then run → one tick gives 00:00:00, with day_wrap and tick_1hz in the same cycle.
- sel=01, minutes 59, one short inc press → minutes 00 and hours unchanged. sel=10, hours 00, one dec press → 23.
- sel=00, hold btn_inc for 20 cycles → steps at N+2, N+8, N+11, N+14, N+17, N+20 (6 total). No tick occurs during the hold.
- Both buttons high with sel=00 → no change. Reset asserted mid-hold → immediate zero, and no step until the button is re-pressed.
- With TIME_CNT_12H_EN: reset → 12:00:00 with pm=0. Set hours to 13 → display 01 with pm=1.

Source files
------------

// File: rtl/bcd_clock_core_if.sv
// -----------------------------------------------------------------------------
// bcd_clock_core_if
// Control and display bundle of the BCD time-of-day core.
//   run               timekeeping enable
//   sel[1:0]          field to set: 00 sec, 01 min, 10 hours, 11 none
//   btn_inc, btn_dec  raw, asynchronous button levels (active-high)
//   sec_lo .. hr_hi   registered BCD display digits
//   tick_1hz          one-cycle pulse on every timekeeping advance
//   day_wrap          one-cycle pulse on 23:59:59 -> 00:00:00
//   pm                PM indicator (12-hour build only, else 0)
// master: drives the controls and reads the digits (button/test side).
// slave:  the clock core itself.
// -----------------------------------------------------------------------------
interface bcd_clock_core_if;
   logic       run;
   logic [1:0] sel;
   logic       btn_inc;
   logic       btn_dec;
   logic [3:0] sec_lo;
   logic [3:0] sec_hi;
   logic [3:0] min_lo;
   logic [3:0] min_hi;
   logic [3:0] hr_lo;
   logic [3:0] hr_hi;
   logic       tick_1hz;
   logic       day_wrap;
   logic       pm;

   modport master (
      output run, sel, btn_inc, btn_dec,
      input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, tick_1hz, day_wrap, pm
   );

   modport slave (
      input  run, sel, btn_inc, btn_dec,
      output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, tick_1hz, day_wrap, pm
   );
endinterface

// File: rtl/bcd_clock_core.sv
// -----------------------------------------------------------------------------
// bcd_clock_core
// Time-of-day counter: divides clk to a 1 s tick, keeps hh:mm:ss as BCD digits
// and lets the user step one field up/down with press-and-hold auto-repeat.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  bcd_clock_core_if.slave (run, sel, buttons in; digits, pulses out)
// Parameters:
//   TICK_DIV       clk cycles per 1 s tick (>= 2)
//   SET_REPEAT     cycles from first step to first auto-repeat step (>= 2)
//   REPEAT_PERIOD  cycles between auto-repeat steps (>= 2)
// Optional build macro TIME_CNT_12H_EN: hour digits shown in 12-hour format
// with pm indicator; otherwise 00..23 and pm is 0.
// -----------------------------------------------------------------------------
module bcd_clock_core #(
   parameter int TICK_DIV      = 50_000_000,
   parameter int SET_REPEAT    = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic             clk,
   input  logic             rst,
   bcd_clock_core_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

   localparam int PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam int CNT_MAX = (SET_REPEAT > REPEAT_PERIOD) ? SET_REPEAT : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // BCD 00..59 field stepped by one, wrapping without carry-out.
   function automatic logic [7:0] bcd60_step(input logic [7:0] v, input logic up);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = v[7:4];
      lo = v[3:0];
      if (up) begin
         if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd5) ? 4'd0 : hi + 4'd1;
         end else begin
            lo = lo + 4'd1;
         end
      end else begin
         if (lo == 4'd0) begin
            lo = 4'd9;
            hi = (hi == 4'd0) ? 4'd5 : hi - 4'd1;
         end else begin
            lo = lo - 4'd1;
         end
      end
      return {hi, lo};
   endfunction

   function automatic logic [4:0] hr_step(input logic [4:0] h, input logic up);
      if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
      else    return (h == 5'd0) ? 5'd23 : h - 5'd1;
   endfunction

   // Internal binary hour -> {pm, hi digit, lo digit} as displayed.
   function automatic logic [8:0] hr_disp(input logic [4:0] h);
      logic [4:0] d;
      logic [4:0] lo;
      logic [3:0] hi;
      logic       pm_v;
`ifdef TIME_CNT_12H_EN
      pm_v = (h >= 5'd12);
      if (h == 5'd0)       d = 5'd12;
      else if (h > 5'd12)  d = h - 5'd12;
      else                 d = h;
`else
      pm_v = 1'b0;
      d    = h;
`endif
      if (d >= 5'd20) begin
         hi = 4'd2;
         lo = d - 5'd20;
      end else if (d >= 5'd10) begin
         hi = 4'd1;
         lo = d - 5'd10;
      end else begin
         hi = 4'd0;
         lo = d;
      end
      return {pm_v, hi, lo[3:0]};
   endfunction

   // ---------------- button synchronisers and edge detect ----------------
   logic       inc_m_reg, inc_s_reg, inc_prev_reg;
   logic       dec_m_reg, dec_s_reg, dec_prev_reg;
   logic [1:0] fill_reg;
   logic       lock_reg;

   // lock_reg blocks the first press after reset until both synchronised
   // levels have been seen low, so a button held through reset never steps.
   // fill_reg waits out the synchroniser pipeline so the "low" is genuine.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inc_m_reg    <= 1'b0;
         inc_s_reg    <= 1'b0;
         inc_prev_reg <= 1'b0;
         dec_m_reg    <= 1'b0;
         dec_s_reg    <= 1'b0;
         dec_prev_reg <= 1'b0;
         fill_reg     <= 2'b00;
         lock_reg     <= 1'b1;
      end else begin
         inc_m_reg    <= bus.btn_inc;
         inc_s_reg    <= inc_m_reg;
         inc_prev_reg <= inc_s_reg;
         dec_m_reg    <= bus.btn_dec;
         dec_s_reg    <= dec_m_reg;
         dec_prev_reg <= dec_s_reg;
         fill_reg     <= {fill_reg[0], 1'b1};
         if (fill_reg[1] && !inc_s_reg && !dec_s_reg)
            lock_reg <= 1'b0;
      end
   end

   // ---------------- button FSM ----------------
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;   // edges since the last step, counting from 1
   logic             dir_reg;   // 1 = increment held

   logic inc_rise, dec_rise, both, active, leave, start, hold_done, rep_done;
   logic step, step_up;

   assign inc_rise  = inc_s_reg & ~inc_prev_reg;
   assign dec_rise  = dec_s_reg & ~dec_prev_reg;
   assign both      = inc_s_reg & dec_s_reg;
   assign active    = dir_reg ? inc_s_reg : dec_s_reg;
   assign leave     = !active || both;
   assign start     = (state_reg == IDLE) && !lock_reg && !both && (inc_rise || dec_rise);
   assign hold_done = (state_reg == HOLD) && !leave && (cnt_reg == CNT_W'(SET_REPEAT));
   assign rep_done  = (state_reg == REPEAT) && !leave && (cnt_reg == CNT_W'(REPEAT_PERIOD));
   assign step      = start || hold_done || rep_done;
   assign step_up   = start ? inc_rise : dir_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= FIRST;
                  dir_reg   <= inc_rise;
                  cnt_reg   <= CNT_W'(1);
               end
            end
            FIRST: begin
               if (leave) state_reg <= IDLE;
               else begin
                  state_reg <= HOLD;
                  cnt_reg   <= cnt_reg + CNT_W'(1);
               end
            end
            HOLD: begin
               if (leave) state_reg <= IDLE;
               else if (hold_done) begin
                  state_reg <= REPEAT;
                  cnt_reg   <= CNT_W'(1);
               end else cnt_reg <= cnt_reg + CNT_W'(1);
            end
            default: begin
               if (leave) state_reg <= IDLE;
               else if (rep_done) cnt_reg <= CNT_W'(1);
               else cnt_reg <= cnt_reg + CNT_W'(1);
            end
         endcase
      end
   end

   // ---------------- prescaler ----------------
   // A held button keeps the prescaler at 0, so a tick and a set step can
   // never land on the same edge.
   logic [PRE_W-1:0] pre_reg;
   logic             tick_now;

   assign tick_now = bus.run && !inc_s_reg && !dec_s_reg && (pre_reg == PRE_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pre_reg <= '0;
      else if (!bus.run || inc_s_reg || dec_s_reg || pre_reg == PRE_LAST)
         pre_reg <= '0;
      else
         pre_reg <= pre_reg + PRE_W'(1);
   end

   // ---------------- time registers ----------------
   logic [7:0] sec_reg, min_reg, sec_next, min_next;
   logic [4:0] hr_reg, hr_next;
   logic [7:0] hr_disp_reg;
   logic       pm_reg, tick_reg, wrap_reg, wrap_now;

   always_comb begin
      sec_next = sec_reg;
      min_next = min_reg;
      hr_next  = hr_reg;
      wrap_now = 1'b0;
      if (tick_now) begin
         sec_next = bcd60_step(sec_reg, 1'b1);
         if (sec_reg == 8'h59) begin
            min_next = bcd60_step(min_reg, 1'b1);
            if (min_reg == 8'h59) begin
               hr_next  = hr_step(hr_reg, 1'b1);
               wrap_now = (hr_reg == 5'd23);
            end
         end
      end else if (step) begin
         case (bus.sel)
            2'b00:   sec_next = bcd60_step(sec_reg, step_up);
            2'b01:   min_next = bcd60_step(min_reg, step_up);
            2'b10:   hr_next  = hr_step(hr_reg, step_up);
            default: ;
         endcase
      end
   end

   // Hour display is converted from hr_next so it updates on the same edge
   // as the other digits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_reg               <= 8'h00;
         min_reg               <= 8'h00;
         hr_reg                <= 5'd0;
         {pm_reg, hr_disp_reg} <= hr_disp(5'd0);
         tick_reg              <= 1'b0;
         wrap_reg              <= 1'b0;
      end else begin
         sec_reg               <= sec_next;
         min_reg               <= min_next;
         hr_reg                <= hr_next;
         {pm_reg, hr_disp_reg} <= hr_disp(hr_next);
         tick_reg              <= tick_now;
         wrap_reg              <= wrap_now;
      end
   end

   assign bus.sec_lo   = sec_reg[3:0];
   assign bus.sec_hi   = sec_reg[7:4];
   assign bus.min_lo   = min_reg[3:0];
   assign bus.min_hi   = min_reg[7:4];
   assign bus.hr_lo    = hr_disp_reg[3:0];
   assign bus.hr_hi    = hr_disp_reg[7:4];
   assign bus.pm       = pm_reg;
   assign bus.tick_1hz = tick_reg;
   assign bus.day_wrap = wrap_reg;

endmodule

// File: tb/tb_bcd_clock_core.sv
// -----------------------------------------------------------------------------
// tb_bcd_clock_core
// Self-checking bench for bcd_clock_core with TICK_DIV=4, SET_REPEAT=6,
// REPEAT_PERIOD=3. Expected displays come from exp_disp(), built from the
// intended internal hour/minute/second values.
// -----------------------------------------------------------------------------
module tb_bcd_clock_core;

   logic clk;
   logic rst;

   bcd_clock_core_if bus ();

   bcd_clock_core #(
      .TICK_DIV      (4),
      .SET_REPEAT    (6),
      .REPEAT_PERIOD (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: runs 1 time unit after each rising edge.
   int cyc_cnt       = 0;
   int tick_cnt      = 0;
   int wrap_cnt      = 0;
   int spacing_bad   = 0;
   int last_tick_cyc = 0;

   always @(posedge clk) begin
      #1;
      cyc_cnt++;
      if (bus.tick_1hz) begin
         tick_cnt++;
         if (cyc_cnt - last_tick_cyc != 4) spacing_bad++;
         last_tick_cyc = cyc_cnt;
      end
      if (bus.day_wrap) wrap_cnt++;
   end

   // Main process always sits 3 time units after a rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // {pm, hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo} expected for an internal time.
   function automatic logic [24:0] exp_disp(input int h, input int m, input int s);
      int   dh;
      logic p;
`ifdef TIME_CNT_12H_EN
      p  = (h >= 12);
      dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
`else
      p  = 1'b0;
      dh = h;
`endif
      return {p, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [24:0] dut_disp();
      return {bus.pm, bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo};
   endfunction

   task automatic do_reset();
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      rst = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(4);
   endtask

   // One short press: button sampled high at exactly one edge.
   task automatic press(input logic [1:0] s, input logic i, input logic d);
      bus.sel     = s;
      bus.btn_inc = i;
      bus.btn_dec = d;
      cyc(1);
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      cyc(6);
   endtask

   typedef struct {
      string      name;
      logic [1:0] sel;
      logic       inc;
      logic       dec;
      int         hr;
      int         mn;
      int         sc;
   } vec_t;

   vec_t vecs[14];

   int steps_q[$];
   int exp_steps[6];

   initial begin
      vecs[0]  = '{"min_dec_wrap",  2'b01, 1'b0, 1'b1,  0, 59,  0};
      vecs[1]  = '{"min_inc_wrap",  2'b01, 1'b1, 1'b0,  0,  0,  0};
      vecs[2]  = '{"hr_dec_wrap",   2'b10, 1'b0, 1'b1, 23,  0,  0};
      vecs[3]  = '{"hr_inc_wrap",   2'b10, 1'b1, 1'b0,  0,  0,  0};
      vecs[4]  = '{"sec_dec_wrap",  2'b00, 1'b0, 1'b1,  0,  0, 59};
      vecs[5]  = '{"sec_inc_wrap",  2'b00, 1'b1, 1'b0,  0,  0,  0};
      vecs[6]  = '{"sel_none",      2'b11, 1'b1, 1'b0,  0,  0,  0};
      vecs[7]  = '{"sec_inc",       2'b00, 1'b1, 1'b0,  0,  0,  1};
      vecs[8]  = '{"min_inc",       2'b01, 1'b1, 1'b0,  0,  1,  1};
      vecs[9]  = '{"hr_inc",        2'b10, 1'b1, 1'b0,  1,  1,  1};
      vecs[10] = '{"both_buttons",  2'b00, 1'b1, 1'b1,  1,  1,  1};
      vecs[11] = '{"hr_dec",        2'b10, 1'b0, 1'b1,  0,  1,  1};
      vecs[12] = '{"min_dec",       2'b01, 1'b0, 1'b1,  0,  0,  1};
      vecs[13] = '{"sec_dec",       2'b00, 1'b0, 1'b1,  0,  0,  0};
      exp_steps = '{2, 8, 11, 14, 17, 20};

      rst         = 1'b0;
      bus.run     = 1'b0;
      bus.sel     = 2'b11;
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;

      // ---------------- reset state ----------------
      do_reset();
      check("reset_digits", 32'(dut_disp()), 32'(exp_disp(0, 0, 0)));
      check("reset_tick", 32'(bus.tick_1hz), 32'd0);
      check("reset_wrap", 32'(bus.day_wrap), 32'd0);

      // ---------------- free run 240 cycles ----------------
      tick_cnt      = 0;
      wrap_cnt      = 0;
      spacing_bad   = 0;
      last_tick_cyc = cyc_cnt;
      bus.run       = 1'b1;
      cyc(240);
      bus.run = 1'b0;
      check("run_digits", 32'(dut_disp()), 32'(exp_disp(0, 1, 0)));
      check("run_ticks", 32'(tick_cnt), 32'd60);
      check("run_spacing", 32'(spacing_bad), 32'd0);
      check("run_no_wrap", 32'(wrap_cnt), 32'd0);

      // ---------------- table of single presses ----------------
      do_reset();
      for (int i = 0; i < 14; i++) begin
         press(vecs[i].sel, vecs[i].inc, vecs[i].dec);
         check(vecs[i].name, 32'(dut_disp()), 32'(exp_disp(vecs[i].hr, vecs[i].mn, vecs[i].sc)));
      end

`ifdef TIME_CNT_12H_EN
      // ---------------- 12-hour display ----------------
      do_reset();
      check("h12_reset", 32'(dut_disp()), 32'h0120000);
      for (int i = 0; i < 13; i++) press(2'b10, 1'b1, 1'b0);
      check("h12_13h", 32'(dut_disp()), 32'h1010000);
`endif

      // ---------------- day wrap ----------------
      do_reset();
      press(2'b00, 1'b0, 1'b1);
      press(2'b01, 1'b0, 1'b1);
      press(2'b10, 1'b0, 1'b1);
      check("preload_235959", 32'(dut_disp()), 32'(exp_disp(23, 59, 59)));
      begin
         int found;
         int at;
         found    = 0;
         at       = 0;
         wrap_cnt = 0;
         bus.run  = 1'b1;
         for (int i = 1; i <= 10 && found == 0; i++) begin
            cyc(1);
            if (bus.tick_1hz) begin
               found = 1;
               at    = i;
               check("wrap_same_cycle", 32'(bus.day_wrap), 32'd1);
               check("wrap_digits", 32'(dut_disp()), 32'(exp_disp(0, 0, 0)));
            end
         end
         bus.run = 1'b0;
         check("wrap_tick_seen", 32'(found), 32'd1);
         check("wrap_tick_latency", 32'(at), 32'd4);
         cyc(2);
         check("wrap_count", 32'(wrap_cnt), 32'd1);
      end

      // ---------------- press and hold auto-repeat ----------------
      do_reset();
      bus.sel = 2'b00;
      cyc(1);
      begin
         int n0;
         int t0;
         logic [7:0] prev;
         steps_q.delete();
         prev        = {bus.sec_hi, bus.sec_lo};
         t0          = tick_cnt;
         bus.run     = 1'b1;
         bus.btn_inc = 1'b1;
         n0          = cyc_cnt + 1;
         for (int k = 0; k < 24; k++) begin
            cyc(1);
            if (k == 19) bus.btn_inc = 1'b0;
            if ({bus.sec_hi, bus.sec_lo} != prev) steps_q.push_back(cyc_cnt - n0);
            prev = {bus.sec_hi, bus.sec_lo};
         end
         bus.run = 1'b0;
         check("hold_step_count", 32'(steps_q.size()), 32'd6);
         for (int j = 0; j < 6; j++)
            check($sformatf("hold_step%0d_edge", j), 32'((j < steps_q.size()) ? steps_q[j] : -1),
                  32'(exp_steps[j]));
         check("hold_no_tick", 32'(tick_cnt - t0), 32'd0);
         check("hold_digits", 32'(dut_disp()), 32'(exp_disp(0, 0, 6)));
      end

      // ---------------- reset mid-hold ----------------
      bus.run     = 1'b0;
      bus.sel     = 2'b00;
      bus.btn_inc = 1'b1;
      cyc(12);
      rst = 1'b0;
      #1;
      check("midhold_reset_now", 32'(dut_disp()), 32'(exp_disp(0, 0, 0)));
      cyc(2);
      rst = 1'b1;
      cyc(15);
      check("held_after_reset", 32'(dut_disp()), 32'(exp_disp(0, 0, 0)));
      bus.btn_inc = 1'b0;
      cyc(4);
      press(2'b00, 1'b1, 1'b0);
      check("repress_after_reset", 32'(dut_disp()), 32'(exp_disp(0, 0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
